// File: rtl/nmax_tree.sv
// nmax_tree: pipelined N-lane min/max finder with lane index and a peak-hold
// register that tracks the running extremum across successive results.
//
// The compare tree lives in one flat node array. Stage k occupies the
// N >> k nodes starting at stage_off(k). Stage 0 holds the registered input
// lanes, and the single node of stage L is the result.
module nmax_tree #(
  parameter int W = 4,
  parameter int N = 8
) (
  input  logic                 CLK,
  input  logic                 RESET_L,
  input  logic                 IN_VALID,
  input  logic                 MODE,
  input  logic [N*W-1:0]       NIBBLES,
  input  logic                 PEAK_CLR,
  output logic                 OUT_VALID,
  output logic [W-1:0]         VAL_OUT,
  output logic [$clog2(N)-1:0] ID_OUT,
  output logic                 MODE_OUT,
  output logic                 PEAK_VALID,
  output logic [W-1:0]         PEAK_VAL,
  output logic [$clog2(N)-1:0] PEAK_ID
);

  localparam int L     = $clog2(N);
  localparam int NODES = 2 * N - 1;

  // First node of tree stage k inside the flat node array.
  function automatic int stage_off(input int k);
    return 2 * N - ((2 * N) >> k);
  endfunction

  // A pair keeps its lower-index candidate a on a tie, in both modes.
  function automatic logic take_a(input logic       min_mode,
                                  input logic [W-1:0] a,
                                  input logic [W-1:0] b);
    return min_mode ? (a <= b) : (a >= b);
  endfunction

  logic [W-1:0] val_q [NODES];
  logic [W-1:0] val_d [NODES];
  logic [L-1:0] id_q  [NODES];
  logic [L-1:0] id_d  [NODES];
  logic [L:0]   vld_q, vld_d;
  logic [L:0]   mode_q, mode_d;

  logic         peak_valid_q, peak_valid_d;
  logic [W-1:0] peak_val_q, peak_val_d;
  logic [L-1:0] peak_id_q, peak_id_d;
  logic         peak_mode_q, peak_mode_d;
  logic         peak_held;
  logic         peak_better;
  logic         peak_load;

  // Pipeline next state: the input capture and the compare tree. Data only
  // moves with a valid slot, so the result outputs hold across bubbles.
  always_comb begin
    // NOTE: every signal written here gets a default first; any path that
    // left one unassigned would infer a latch.
    val_d  = val_q;
    id_d   = id_q;
    vld_d  = vld_q;
    mode_d = mode_q;

    vld_d[0] = IN_VALID;
    if (IN_VALID) begin
      mode_d[0] = MODE;
      for (int i = 0; i < N; i++) begin
        val_d[i] = NIBBLES[i*W +: W];
        id_d[i]  = L'(i);
      end
    end

    for (int k = 1; k <= L; k++) begin
      vld_d[k] = vld_q[k-1];
      if (vld_q[k-1]) begin
        mode_d[k] = mode_q[k-1];
        for (int j = 0; j < (N >> k); j++) begin
          if (take_a(mode_q[k-1], val_q[stage_off(k-1) + 2*j],
                     val_q[stage_off(k-1) + 2*j + 1])) begin
            val_d[stage_off(k) + j] = val_q[stage_off(k-1) + 2*j];
            id_d[stage_off(k) + j]  = id_q[stage_off(k-1) + 2*j];
          end else begin
            val_d[stage_off(k) + j] = val_q[stage_off(k-1) + 2*j + 1];
            id_d[stage_off(k) + j]  = id_q[stage_off(k-1) + 2*j + 1];
          end
        end
      end
    end
  end

  // Pipeline registers. The synchronous reset drops every in-flight vector.
  always_ff @(posedge CLK) begin
    if (!RESET_L) begin
      // NOTE: the node array is reset on purpose. The result and peak
      // outputs must read 0 after reset, not whatever was left in flight.
      for (int i = 0; i < NODES; i++) begin
        val_q[i] <= '0;
        id_q[i]  <= '0;
      end
      vld_q  <= '0;
      mode_q <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every stage samples the values
      // its predecessor held before this edge.
      val_q  <= val_d;
      id_q   <= id_d;
      vld_q  <= vld_d;
      mode_q <= mode_d;
    end
  end

  assign OUT_VALID = vld_q[L];
  assign VAL_OUT   = val_q[NODES-1];
  assign ID_OUT    = id_q[NODES-1];
  assign MODE_OUT  = mode_q[L];

  // Peak-hold next state. A clear empties the register first, and a result
  // presented in the same cycle then loads into the emptied register.
  always_comb begin
    peak_valid_d = peak_valid_q;
    peak_val_d   = peak_val_q;
    peak_id_d    = peak_id_q;
    peak_mode_d  = peak_mode_q;
    peak_held    = peak_valid_q;

    if (PEAK_CLR) begin
      peak_valid_d = 1'b0;
      peak_val_d   = '0;
      peak_id_d    = '0;
      peak_mode_d  = 1'b0;
      peak_held    = 1'b0;
    end

    // Strictly better only: on equality the earlier result is kept.
    peak_better = MODE_OUT ? (VAL_OUT < peak_val_q) : (VAL_OUT > peak_val_q);
    peak_load   = OUT_VALID &&
                  (!peak_held || (MODE_OUT != peak_mode_q) || peak_better);

    if (peak_load) begin
      peak_valid_d = 1'b1;
      peak_val_d   = VAL_OUT;
      peak_id_d    = ID_OUT;
      peak_mode_d  = MODE_OUT;
    end
  end

  // Peak-hold registers.
  always_ff @(posedge CLK) begin
    if (!RESET_L) begin
      peak_valid_q <= 1'b0;
      peak_val_q   <= '0;
      peak_id_q    <= '0;
      peak_mode_q  <= 1'b0;
    end else begin
      peak_valid_q <= peak_valid_d;
      peak_val_q   <= peak_val_d;
      peak_id_q    <= peak_id_d;
      peak_mode_q  <= peak_mode_d;
    end
  end

  assign PEAK_VALID = peak_valid_q;
  assign PEAK_VAL   = peak_val_q;
  assign PEAK_ID    = peak_id_q;

endmodule

// File: doc/nmax_tree.md
# nmax_tree

Parametrised, fully pipelined extremum finder: takes N lanes of W-bit values packed on one bus and returns the largest or smallest value and its lane index. It has one compare stage per tree level and accepts a new vector every cycle. A peak-hold register tracks the running extremum across successive results until cleared. This block is the generalised successor to the 4-lane nibble-maximum unit in the datapath. It adds a valid handshake, a min/max mode and streaming peak detection.

## Interface
- W, 4: bits per lane.
- N, 8: lane count; power of two, N >= 2.
- L, log2(N): derived, not overridable; tree depth and index width.
- CLK  input  1  rising-edge clock.
- RESET_L  input  1  synchronous, active-low reset.
- IN_VALID  input  1  NIBBLES/MODE valid this cycle.
- MODE  input  1  0 = maximum, 1 = minimum; sampled with IN_VALID.
- NIBBLES  input  N*W  lane i at [i*W +: W], unsigned.
- PEAK_CLR  input  1  empty the peak-hold register.
- OUT_VALID  output  1  VAL_OUT/ID_OUT/MODE_OUT carry a new result.
- VAL_OUT  output  W  extremum value.
- ID_OUT  output  L  lane index of VAL_OUT.
- MODE_OUT  output  1  mode the result was computed under.
- PEAK_VALID  output  1  peak register holds a value.
- PEAK_VAL  output  W  held extremum.
- PEAK_ID  output  L  lane index of held extremum.

## Operation
- Stage 0 registers NIBBLES, MODE and IN_VALID. Each lane's index travels with its value.
- Stages 1..L form a binary compare tree. Stage k reduces N/2^(k-1) candidates to N/2^k; each pair compares the lower-index candidate (a) with the higher-index candidate (b).
- MAX mode: select a if a >= b, else b. MIN mode: select a if a <= b, else b. Ties always go to the lower lane index.
- Comparisons are unsigned and W bits wide; there is no arithmetic growth.
- A valid bit and the mode bit travel through every stage. A bubble (IN_VALID=0) moves through as an invalid slot.
- When OUT_VALID=0, VAL_OUT, ID_OUT and MODE_OUT hold their last valid values.
- Peak hold is updated on every cycle with OUT_VALID=1:
  - Load the result when any of these is true: PEAK_VALID=0; MODE_OUT differs from the stored peak mode; or the result is strictly better than the held peak (strictly greater in MAX, strictly less in MIN).
  - Otherwise keep the held peak. On equality the earlier result wins.
- PEAK_CLR=1 empties the peak register (PEAK_VALID=0).
  - PEAK_CLR and OUT_VALID in the same cycle: the clear takes effect first, then the result loads, so PEAK_VALID=1 holding the new result.
  - PEAK_CLR alone: PEAK_VALID=0 next cycle; PEAK_VAL and PEAK_ID go to 0.
- Reset (RESET_L=0 at a clock edge):
  - All pipeline registers and valid bits clear. OUT_VALID, VAL_OUT, ID_OUT, MODE_OUT, PEAK_VALID, PEAK_VAL and PEAK_ID are all 0.
  - Reset mid-stream discards every in-flight vector; no stale result ever appears after reset.

## Timing
- Latency from a vector sampled with IN_VALID=1 at edge t to OUT_VALID=1 after edge t+L is L+1 cycles: 4 for N=8, 2 for N=2.
- Throughput is one vector per cycle. There is no backpressure and no stall; results leave in input order.
- The peak registers update at the same edge where OUT_VALID rises plus one. PEAK_* reflect a result one cycle after that result is presented on OUT_VALID/VAL_OUT.
- Inputs take effect on the first rising edge with RESET_L=1.

## Test plan
- N=8, W=4, MAX. Lanes 0..7 = 3,9,1,9,0,2,7,4, IN_VALID pulse -> 4 cycles later OUT_VALID=1, VAL_OUT=9, ID_OUT=1 (tie goes to the lower index).
- Same vector in MIN mode -> VAL_OUT=0, ID_OUT=4, MODE_OUT=1.
- Stream 6 vectors back-to-back, alternating modes, with a bubble after the 3rd -> 6 results in order at one per cycle, with one OUT_VALID=0 gap in the matching position.
- MAX results 5 (lane 2), 12 (lane 6), 12 (lane 1), then 7 with PEAK_CLR in the same cycle -> peak goes 5/2, 12/6, 12/6, then 7.
- Three vectors in flight, RESET_L low for one cycle -> all outputs are 0 next cycle and OUT_VALID stays 0 until a new vector is sent.
- N=2, W=8, MAX. Lanes 0x80, 0x7F -> VAL_OUT=0x80, ID_OUT=0, latency 2. MIN mode -> VAL_OUT=0x7F, ID_OUT=1.
